// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: Moore decode of datapath strobes/selects,
// memory stall handling with a watchdog to ERR. Optional addi support: define MULTICYCLE_ADDI_EN.
module multicycle_main_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       err,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
`ifdef MULTICYCLE_ADDI_EN
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
`endif
        S_ERR     = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_state;

    // Unqualified strobes; reset gating is applied at the ports.
    logic mem_read_s, mem_write_s, ir_write_s, pc_write_s, pc_write_cond_s, reg_write_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and watchdog counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        stall_state = 1'b0;
        case (state_q)
            S_FETCH: begin
                stall_state = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_ERR;
            end
            S_MEMRD: begin
                stall_state = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                stall_state = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
`endif
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase

        // A completing access in the last allowed cycle still wins over the timeout
        if (stall_state && !mem_ready) begin
            if ((WAIT_MAX != 0) && (cnt_q == CNT_MAX)) begin
                state_d = S_ERR;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output decode from the state register (FETCH load strobes follow mem_ready)
    always_comb begin
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        reg_write_s     = 1'b0;
        iord            = 1'b0;
        pc_source       = 2'b00;
        alu_op          = 2'b00;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        err             = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source       = 2'b01;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = 2'b10;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: reg_write_s = 1'b1;
`endif
            S_ERR:   err = 1'b1;
            default: err = 1'b0;
        endcase
    end

    assign mem_read      = mem_read_s & ~rst;
    assign mem_write     = mem_write_s & ~rst;
    assign mem_req       = (mem_read_s | mem_write_s) & ~rst;
    assign ir_write      = ir_write_s & ~rst;
    assign pc_write      = pc_write_s & ~rst;
    assign pc_write_cond = pc_write_cond_s & ~rst;
    assign reg_write     = reg_write_s & ~rst;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Randomized bench for multicycle_main_ctrl: per-instruction expected state traces built from
// the instruction-level rules, compared cycle by cycle against the DUT.
module tb_multicycle_main_ctrl;

    localparam int unsigned WAIT_MAX = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, err;
    logic [3:0] state;

    multicycle_main_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .err(err),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [17:0] dut_out;
    assign dut_out = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                      pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, err};

    // Reset view: every strobe low, selects at their FETCH values
    localparam logic [17:0] RST_EXP = {7'b0, 2'b00, 2'b00, 1'b0, 2'b01, 4'b0};

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for a state, straight from the state table
    function automatic logic [17:0] exp_out(input logic [3:0] st, input logic rdy);
        logic mr, mw, io, irw, pw, pwc, sa, rw, rd, m2r, e;
        logic [1:0] ps, ao, sb;
        mr = 0; mw = 0; io = 0; irw = 0; pw = 0; pwc = 0; sa = 0; rw = 0; rd = 0; m2r = 0; e = 0;
        ps = 2'b00; ao = 2'b00; sb = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; io = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            4'd9:  begin pw = 1; ps = 2'b10; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: rw = 1;
            4'd15: e = 1;
            default: e = 0;
        endcase
        return {mr | mw, mr, mw, io, irw, pw, pwc, ps, ao, sa, sb, rw, rd, m2r, e};
    endfunction

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } cyc_t;

    cyc_t       trace[$];
    logic [5:0] cur_op;

    task automatic push(input logic [3:0] st, input logic rdy);
        cyc_t c;
        c.st  = st;
        c.rdy = rdy;
        trace.push_back(c);
    endtask

    task automatic push_any(input logic [3:0] st);
        push(st, 1'($urandom_range(0, 1)));
    endtask

    // Memory phase: 'stalls' not-ready cycles then completion, or timeout into ERR
    task automatic add_mem(input logic [3:0] st, input int unsigned stalls, output bit ok);
        if (WAIT_MAX != 0 && stalls > WAIT_MAX) begin
            for (int i = 0; i <= int'(WAIT_MAX); i++) push(st, 1'b0);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < int'(stalls); i++) push(st, 1'b0);
            push(st, 1'b1);
            ok = 1'b1;
        end
    endtask

    task automatic add_err();
        for (int i = 0; i < 3; i++) push_any(4'd15);
    endtask

    function automatic bit addi_on();
`ifdef MULTICYCLE_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic build(input logic [5:0] op, input int unsigned sf, input int unsigned sm,
                         output bit errd);
        bit ok;
        trace.delete();
        cur_op = op;
        errd   = 1'b0;
        add_mem(4'd0, sf, ok);
        if (!ok) begin add_err(); errd = 1'b1; return; end
        push_any(4'd1);
        if (op == OP_LW || op == OP_SW) begin
            push_any(4'd2);
            add_mem((op == OP_LW) ? 4'd3 : 4'd5, sm, ok);
            if (!ok) begin add_err(); errd = 1'b1; return; end
            if (op == OP_LW) push_any(4'd4);
        end else if (op == OP_RTYPE) begin
            push_any(4'd6); push_any(4'd7);
        end else if (op == OP_BEQ) begin
            push_any(4'd8);
        end else if (op == OP_J) begin
            push_any(4'd9);
        end else if (op == OP_ADDI && addi_on()) begin
            push_any(4'd10); push_any(4'd11);
        end else begin
            add_err();
            errd = 1'b1;
        end
    endtask

    // Entered and left at a falling edge; releases reset at that edge
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_outs", 32'(dut_out), 32'(RST_EXP));
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_eq("rst_hold_outs", 32'(dut_out), 32'(RST_EXP));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Replays the trace; if stop_st >= 0, resets asynchronously mid-cycle in that state
    task automatic run_trace(input int stop_st);
        for (int i = 0; i < trace.size(); i++) begin
            opcode    = (trace[i].st == 4'd0) ? 6'($urandom) : cur_op;
            mem_ready = trace[i].rdy;
            #1;
            check_eq($sformatf("state_exp%0d", trace[i].st), 32'(state), 32'(trace[i].st));
            check_eq($sformatf("outs_st%0d", trace[i].st), 32'(dut_out),
                     32'(exp_out(trace[i].st, trace[i].rdy)));
            if (stop_st >= 0 && int'(trace[i].st) == stop_st) begin
                #2;
                rst = 1'b1;
                #1;
                check_eq("async_rst_state", 32'(state), 32'd0);
                check_eq("async_rst_outs", 32'(dut_out), 32'(RST_EXP));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input int unsigned sf, input int unsigned sm);
        bit errd;
        build(op, sf, sm, errd);
        run_trace(-1);
        if (errd) do_reset();
    endtask

    function automatic int unsigned pick_stall();
        if (WAIT_MAX > 1 && $urandom_range(0, 19) == 0)
            return $urandom_range(WAIT_MAX - 1, WAIT_MAX + 2);
        return $urandom_range(0, 3);
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = OP_RTYPE;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_J;
            5: op = OP_ADDI;
            default: begin
                op = 6'($urandom);
                while (op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                       op == OP_J || op == OP_ADDI)
                    op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    initial begin
        bit errd;
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(negedge clk);
        do_reset();

        do_instr(OP_RTYPE, 0, 0);
        do_instr(OP_LW, 0, 3);
        do_instr(OP_SW, 1, 2);
        do_instr(OP_BEQ, 0, 0);
        do_instr(OP_J, 2, 0);
        do_instr(OP_ADDI, 0, 0);
        do_instr(OP_RTYPE, WAIT_MAX + 1, 0);
        do_instr(OP_LW, WAIT_MAX, WAIT_MAX);
        do_instr(OP_LW, 0, WAIT_MAX + 1);
        do_instr(OP_SW, 0, WAIT_MAX + 1);
        do_instr(6'b111111, 0, 0);

        build(OP_SW, 0, 3, errd);
        run_trace(5);
        do_instr(OP_RTYPE, 0, 0);

        for (int n = 0; n < 150; n++) begin
            do_instr(pick_op(), pick_stall(), pick_stall());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
